rbcp_regfile: RTL

RBCP_REGFILE -- requirements
Module: rbcp_regfile

---
 rtl/rbcp_regfile_if.sv | 12 +
 rtl/rbcp_regfile.sv | 122 ++++++++++++
 2 files changed

// File: rtl/rbcp_regfile_if.sv
// RBCP register bus: one address/data beat per access, single-cycle ack.
interface rbcp_if;
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic        re;
    logic [7:0]  rd;
    logic        ack;

    modport slave  (input addr, we, wd, re, output rd, ack);
    modport master (output addr, we, wd, re, input rd, ack);
endinterface

// File: rtl/rbcp_regfile.sv
// Byte-wide RBCP register file with per-register mode (RW, RO, PULSE, W1C).
// An access is sampled on one edge and acked in the following cycle; writes
// take effect at the end of the ack cycle, so reads issued back-to-back see
// the pending write through a forwarding path.
module rbcp_regfile #(
    parameter logic [31:0]         BASE_ADDR = 32'h0000_0000,
    parameter int                  N_REGS    = 8,
    parameter logic [2*N_REGS-1:0] MODE      = '0,
    parameter logic [8*N_REGS-1:0] INIT      = '0
) (
    input  logic                clk,
    input  logic                rst,
    rbcp_if.slave               rbcp_in,
    output logic [8*N_REGS-1:0] reg_q,
    output logic [8*N_REGS-1:0] pulse_q,
    input  logic [8*N_REGS-1:0] hw_in,
    output logic                addr_err
);

    localparam int         IW      = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [1:0] M_RW    = 2'd0;
    localparam logic [1:0] M_RO    = 2'd1;
    localparam logic [1:0] M_PULSE = 2'd2;

    logic [31:0]         off;
    logic                in_range;
    logic                acc;
    logic                acc_wr;
    logic [IW-1:0]       acc_idx;
    logic                ack_q;
    logic                err_q;
    logic [7:0]          rd_q;
    logic                wr_pend_q;
    logic [IW-1:0]       wr_idx_q;
    logic [7:0]          wr_data_q;
    logic [8*N_REGS-1:0] pulse_d;
    logic [7:0]          rv [N_REGS];

    assign off      = rbcp_in.addr - BASE_ADDR;
    assign in_range = (rbcp_in.addr >= BASE_ADDR) && (off < 32'(N_REGS));
    assign acc      = rbcp_in.re | rbcp_in.we;
    assign acc_wr   = rbcp_in.we & ~rbcp_in.re & in_range;
    assign acc_idx  = off[IW-1:0];

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        logic [7:0] byte_q;
        logic [7:0] byte_d;
        logic [7:0] rdv;
        logic [7:0] hw;
        logic       hit;

        assign hw  = hw_in[8*i +: 8];
        assign hit = wr_pend_q && (wr_idx_q == IW'(i));

        // Next state and read view; a read sees a pending write but not this cycle's hw set
        always_comb begin
            byte_d = byte_q;
            rdv    = byte_q;
            case (MODE[2*i +: 2])
                M_RW: begin
                    if (hit) byte_d = wr_data_q;
                    rdv = byte_d;
                end
                M_RO: begin
                    byte_d = hw;
                    rdv    = hw;
                end
                M_PULSE: begin
                    byte_d = 8'h00;
                    rdv    = 8'h00;
                end
                default: begin
                    rdv    = hit ? (byte_q & ~wr_data_q) : byte_q;
                    byte_d = rdv | hw;
                end
            endcase
        end

        // Register byte; only RW registers carry a non-zero reset value
        always_ff @(posedge clk) begin
            if (rst) byte_q <= (MODE[2*i +: 2] == M_RW) ? INIT[8*i +: 8] : 8'h00;
            else     byte_q <= byte_d;
        end

        assign reg_q[8*i +: 8] = byte_q;
        assign rv[i]           = rdv;
    end

    // Strobe for a write to a PULSE register, presented during the ack cycle
    always_comb begin
        pulse_d = '0;
        if (acc_wr && (MODE[2*acc_idx +: 2] == M_PULSE))
            pulse_d[8*acc_idx +: 8] = rbcp_in.wd;
    end

    // Access stage: capture ack/error, read data and the write to apply next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 8'h00;
            pulse_q   <= '0;
            wr_pend_q <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= 8'h00;
        end else begin
            ack_q     <= acc & in_range;
            err_q     <= acc & ~in_range;
            pulse_q   <= pulse_d;
            wr_pend_q <= acc_wr;
            wr_idx_q  <= acc_idx;
            wr_data_q <= rbcp_in.wd;
            if (acc && in_range && rbcp_in.re) rd_q <= rv[acc_idx];
        end
    end

    // Reset arriving in the ack cycle abandons the access, so the ack is masked too
    assign rbcp_in.ack = ack_q & ~rst;
    assign rbcp_in.rd  = rd_q;
    assign addr_err    = err_q;

endmodule
